data_memory_mmio: RTL and testbench

Data-side memory responder for the single-cycle MIPS core. It answers the core's load/store port with combinational reads and clocked writes. It combines a word RAM with a memory-mapped cycle counter and a buffered byte console. The console drains to an external sink over a valid/ready handshake.

---
 rtl/data_memory_mmio_pkg.sv | 30 +++
 rtl/data_memory_mmio_console_fifo.sv | 49 ++++
 rtl/data_memory_mmio.sv | 105 ++++++++++
 tb/tb_data_memory_mmio.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_mmio_pkg.sv
// Shared constants and decode types for the data-side memory responder.
// Holds the MMIO address map, STATUS bit positions and the decode-select enum.
package data_memory_mmio_pkg;

  localparam logic [31:0] ADDR_CYCLES      = 32'hFFFF0000;
  localparam logic [31:0] ADDR_CONSOLE     = 32'hFFFF0004;
  localparam logic [31:0] ADDR_STATUS      = 32'hFFFF0008;
  localparam logic [31:0] DEFAULT_RAM_BASE = 32'h10010000;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_CYCLES,
    SEL_CONSOLE,
    SEL_STATUS,
    SEL_NONE
  } sel_t;

  // Word-granular match against the fixed MMIO registers; RAM is decoded by the top.
  function automatic sel_t mmio_sel(input logic [29:0] word_addr);
    if (word_addr == ADDR_CYCLES[31:2])       return SEL_CYCLES;
    else if (word_addr == ADDR_CONSOLE[31:2]) return SEL_CONSOLE;
    else if (word_addr == ADDR_STATUS[31:2])  return SEL_STATUS;
    else                                      return SEL_NONE;
  endfunction

endpackage

// File: rtl/data_memory_mmio_console_fifo.sv
// Byte FIFO buffering console output; pointers carry an extra wrap bit so
// full/empty fall out of a plain pointer comparison.
module console_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full,
  output logic       drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [7:0]  mem [DEPTH];
  logic        do_pop;
  logic        do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot this same edge, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign head = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/data_memory_mmio.sv
// Data-side memory responder: word RAM, free-running cycle counter and a
// buffered byte console, all behind one combinational-read load/store port.
module data_memory_mmio
  import data_memory_mmio_pkg::*;
#(
  parameter int          MEM_WORDS  = 64,
  parameter logic [31:0] RAM_BASE   = DEFAULT_RAM_BASE,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [31:0]      ram [MEM_WORDS];
  logic [31:0]      cycles;
  logic             overflow;
  logic [29:0]      word_off;
  logic [IDX_W-1:0] ram_idx;
  logic             in_ram;
  sel_t             sel;
  logic [31:0]      status;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_drop;
  logic             con_push;
  logic [1:0]       unused_addr_bits;

  assign unused_addr_bits = addr[1:0];

  // Unsigned word offset from RAM_BASE: addresses below the base wrap high and miss.
  assign word_off = addr[31:2] - RAM_BASE[31:2];
  assign ram_idx  = word_off[IDX_W-1:0];
  assign in_ram   = (word_off[29:IDX_W] == '0);

  always_comb begin
    sel = SEL_NONE;
    if (in_ram) sel = SEL_RAM;
    else        sel = mmio_sel(addr[31:2]);
  end

  always_comb begin
    status           = '0;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = overflow;
  end

  always_comb begin
    readdata = '0;
    case (sel)
      SEL_RAM:    readdata = ram[ram_idx];
      SEL_CYCLES: readdata = cycles;
      SEL_STATUS: readdata = status;
      default:    readdata = '0;
    endcase
  end

  // RAM ignores reset entirely: contents survive and stores still land.
  always_ff @(posedge clk) begin
    if (memwrite && sel == SEL_RAM) ram[ram_idx] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset)                                cycles <= '0;
    else if (memwrite && sel == SEL_CYCLES)   cycles <= writedata;
    else                                      cycles <= cycles + 32'd1;
  end

  // Sticky overflow: a dropped push outranks a same-cycle STATUS clear.
  always_ff @(posedge clk) begin
    if (reset)                                overflow <= 1'b0;
    else if (fifo_drop)                       overflow <= 1'b1;
    else if (memwrite && sel == SEL_STATUS)   overflow <= 1'b0;
  end

  assign con_push = memwrite && (sel == SEL_CONSOLE) && !reset;

  // Console handshake: a byte transfers on every edge where con_valid && con_ready;
  // con_data is held while con_valid is high and con_ready is low.
  console_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_console_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (con_push),
    .push_data(writedata[7:0]),
    .pop      (con_ready),
    .head     (con_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .drop     (fifo_drop)
  );

  assign con_valid = !fifo_empty;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: a driver queues expected load data and
// console bytes; a negedge monitor pops and compares as the DUT presents them.
module tb_data_memory_mmio;

  localparam logic [31:0] A_CYC = 32'hFFFF0000;
  localparam logic [31:0] A_CON = 32'hFFFF0004;
  localparam logic [31:0] A_ST  = 32'hFFFF0008;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;

  logic        rdy;
  logic        rd_chk;
  logic        v_chk;
  logic        v_exp;
  logic [31:0] rd_q[$];
  logic [7:0]  con_q[$];
  int          checks;
  int          failures;

  data_memory_mmio dut (
    .clk      (clk),
    .reset    (reset),
    .memwrite (memwrite),
    .addr     (addr),
    .writedata(writedata),
    .readdata (readdata),
    .con_valid(con_valid),
    .con_data (con_data),
    .con_ready(con_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: one call = one cycle of core activity
  task automatic cyc(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d,
                     input logic crd, input logic [31:0] erd, input logic cv, input logic ev);
    @(posedge clk);
    #1;
    reset     = r;
    memwrite  = we;
    addr      = a;
    writedata = d;
    con_ready = rdy;
    rd_chk    = crd;
    v_chk     = cv;
    v_exp     = ev;
    if (crd) rd_q.push_back(erd);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    cyc(1'b0, 1'b0, a, 32'h0, 1'b1, e, 1'b0, 1'b0);
  endtask

  task automatic rdv(input logic [31:0] a, input logic [31:0] e, input logic ev);
    cyc(1'b0, 1'b0, a, 32'h0, 1'b1, e, 1'b1, ev);
  endtask

  task automatic idlev(input logic ev);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, ev);
  endtask

  task automatic push_con(input logic [7:0] b, input logic expect_out, input logic cv, input logic ev);
    cyc(1'b0, 1'b1, A_CON, {24'h0, b}, 1'b0, 32'h0, cv, ev);
    if (expect_out) con_q.push_back(b);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] e;
    logic [7:0]  eb;
    if (rd_chk) begin
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL readdata addr=%h: no expected value queued, got %h", addr, readdata);
      end else begin
        e = rd_q.pop_front();
        if (readdata !== e) begin
          failures++;
          $display("FAIL readdata addr=%h got=%h exp=%h t=%0t", addr, readdata, e, $time);
        end
      end
    end
    if (v_chk) begin
      checks++;
      if (con_valid !== v_exp) begin
        failures++;
        $display("FAIL con_valid got=%b exp=%b t=%0t", con_valid, v_exp, $time);
      end
    end
    if (con_valid && con_ready) begin
      checks++;
      if (con_q.size() == 0) begin
        failures++;
        $display("FAIL con_byte unexpected got=%h t=%0t", con_data, $time);
      end else begin
        eb = con_q.pop_front();
        if (con_data !== eb) begin
          failures++;
          $display("FAIL con_byte got=%h exp=%h t=%0t", con_data, eb, $time);
        end
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    memwrite  = 1'b0;
    addr      = 32'h0;
    writedata = 32'h0;
    con_ready = 1'b0;
    rdy       = 1'b0;
    rd_chk    = 1'b0;
    v_chk     = 1'b0;
    v_exp     = 1'b0;

    // reset state; a RAM store during reset must still land, console push must not
    cyc(1'b1, 1'b1, 32'h10010008, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, A_ST,  32'h0, 1'b1, 32'h1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, A_CYC, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, A_CON, 32'h5A, 1'b0, 32'h0, 1'b0, 1'b0);
    rdv(A_ST, 32'h1, 1'b0);

    // RAM
    wr(32'h10010004, 32'hDEADBEEF);
    wr(32'h10010000, 32'h12345678);
    rd(32'h10010004, 32'hDEADBEEF);
    rd(32'h10010000, 32'h12345678);
    rd(32'h10010008, 32'h0BADF00D);
    rd(32'h10010007, 32'hDEADBEEF);
    wr(32'h20000000, 32'hFFFFFFFF);
    rd(32'h10010000, 32'h12345678);
    rd(32'h00000000, 32'h0);
    rd(32'h1000FFFC, 32'h0);
    rd(32'h10010100, 32'h0);
    rd(A_CON, 32'h0);

    // cycle counter: count from reset, then load and wrap
    cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) idlev(1'b0);
    rd(A_CYC, 32'd10);
    wr(A_CYC, 32'hFFFFFFFE);
    rd(A_CYC, 32'hFFFFFFFE);
    rd(A_CYC, 32'hFFFFFFFF);
    rd(A_CYC, 32'h0);

    // fill, overflow, drain, clear
    rdy = 1'b0;
    push_con(8'h41, 1'b1, 1'b1, 1'b0);
    push_con(8'h42, 1'b1, 1'b1, 1'b1);
    push_con(8'h43, 1'b1, 1'b0, 1'b0);
    push_con(8'h44, 1'b1, 1'b0, 1'b0);
    rdv(A_ST, 32'h2, 1'b1);
    push_con(8'h45, 1'b0, 1'b1, 1'b1);
    rdv(A_ST, 32'h6, 1'b1);
    rdv(A_ST, 32'h6, 1'b1);
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) idlev(1'b1);
    rdv(A_ST, 32'h5, 1'b0);
    wr(A_ST, 32'h0);
    rdv(A_ST, 32'h1, 1'b0);

    // push into a full FIFO while it pops
    rdy = 1'b0;
    push_con(8'h61, 1'b1, 1'b0, 1'b0);
    push_con(8'h62, 1'b1, 1'b0, 1'b0);
    push_con(8'h63, 1'b1, 1'b0, 1'b0);
    push_con(8'h64, 1'b1, 1'b0, 1'b0);
    rdy = 1'b1;
    push_con(8'h58, 1'b1, 1'b1, 1'b1);
    rdv(A_ST, 32'h2, 1'b1);
    for (int i = 0; i < 3; i++) idlev(1'b1);
    rdv(A_ST, 32'h1, 1'b0);

    // no bypass into an empty FIFO
    push_con(8'h51, 1'b1, 1'b1, 1'b0);
    idlev(1'b1);
    idlev(1'b0);

    // reset discards queued bytes, keeps RAM
    rdy = 1'b0;
    push_con(8'h6D, 1'b0, 1'b0, 1'b0);
    push_con(8'h6E, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, A_ST, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    rdv(A_CYC, 32'h0, 1'b0);
    rdv(A_ST, 32'h1, 1'b0);
    rd(32'h10010004, 32'hDEADBEEF);
    rd(32'h10010000, 32'h12345678);
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) idlev(1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (con_q.size() != 0 || rd_q.size() != 0) begin
      failures++;
      $display("FAIL leftover con_q=%0d rd_q=%0d exp=0", con_q.size(), rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
